// File: rtl/dram_refresh_arb.sv
// dram_refresh_arb: arbitrates a single four-phase DRAM command channel
// between an access requester and a periodic all-bank refresh engine.
// A free-running down-counter emits refresh ticks. Each tick adds to a
// saturating pending count, and every completed burst of NUM_OF_BANKS
// refresh commands removes one from it.
// Optional build macro: REFRESH_POSTPONE_EN. When it is defined, accesses
// may postpone refresh until the pending count saturates. When it is not
// defined, refresh has strict priority whenever any refresh is pending.
module dram_refresh_arb #(
    parameter int NUM_OF_BANKS     = 8,
    parameter int NUM_OF_ROWS      = 128,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int MAX_PENDING      = 4
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic                            acc_req,
    input  logic [1:0]                      acc_cmd,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] acc_bank,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  acc_row,
    output logic                            acc_gnt,
    output logic                            cmd_req,
    output logic [1:0]                      cmd,
    output logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
    input  logic                            cmd_ack,
    output logic                            refresh_flag,
    output logic                            refresh_ovf
);

    localparam int BW = $clog2(NUM_OF_BANKS);
    localparam int RW = $clog2(NUM_OF_ROWS);
    localparam int CW = $clog2(REFRESH_INTERVAL);
    localparam int PW = $clog2(MAX_PENDING + 1);

    localparam logic [CW-1:0] CNT_RELOAD = CW'(REFRESH_INTERVAL - 1);
    localparam logic [BW-1:0] LAST_BANK  = BW'(NUM_OF_BANKS - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(NUM_OF_ROWS - 1);
    localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_REF   = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_REQ = 3'd1,
        ACC_REL = 3'd2,
        REF_REQ = 3'd3,
        REF_REL = 3'd4
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [PW-1:0]   pending_r;
    logic [RW-1:0]   row_ptr_r;

    logic            tick_s;
    logic            acc_valid_s;
    logic            pend_any_s;
    logic            pend_full_s;
    logic            ref_go_s;
    logic            burst_done_s;

    // Decode the tick, the request qualifiers and the IDLE arbitration decision.
    always_comb begin
        tick_s       = (cnt_r == {CW{1'b0}});
        acc_valid_s  = acc_req && ((acc_cmd == CMD_READ) || (acc_cmd == CMD_WRITE));
        pend_any_s   = (pending_r != {PW{1'b0}});
        pend_full_s  = (pending_r == PEND_MAX);
        burst_done_s = (state_r == REF_REL) && !cmd_ack && (bank_id == LAST_BANK);
`ifdef REFRESH_POSTPONE_EN
        // A valid access postpones refresh until the pending count is full.
        ref_go_s     = pend_any_s && (!acc_valid_s || pend_full_s);
`else
        ref_go_s     = pend_any_s;
`endif
    end

    // Refresh interval down-counter; reloads and ticks when it reaches zero.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_r <= CNT_RELOAD;
        end else if (tick_s) begin
            cnt_r <= CNT_RELOAD;
        end else begin
            cnt_r <= cnt_r - CW'(1);
        end
    end

    // Pending count and overflow. A tick and a burst completion in the same
    // cycle cancel each other out.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pending_r   <= {PW{1'b0}};
            refresh_ovf <= 1'b0;
        end else begin
            if (tick_s && !burst_done_s) begin
                if (!pend_full_s) begin
                    pending_r <= pending_r + PW'(1);
                end else begin
                    pending_r <= pending_r;
                end
            end else if (!tick_s && burst_done_s && pend_any_s) begin
                pending_r <= pending_r - PW'(1);
            end else begin
                pending_r <= pending_r;
            end
            if (tick_s && pend_full_s) begin
                refresh_ovf <= 1'b1;
            end else begin
                refresh_ovf <= refresh_ovf;
            end
        end
    end

    // Refresh row pointer; advances once per completed burst and wraps in place.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            row_ptr_r <= {RW{1'b0}};
        end else if (burst_done_s) begin
            if (row_ptr_r == LAST_ROW) begin
                row_ptr_r <= {RW{1'b0}};
            end else begin
                row_ptr_r <= row_ptr_r + RW'(1);
            end
        end else begin
            row_ptr_r <= row_ptr_r;
        end
    end

    // Channel FSM with registered command outputs, grant pulse and refresh flag.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r      <= IDLE;
            cmd_req      <= 1'b0;
            cmd          <= CMD_NONE;
            bank_id      <= {BW{1'b0}};
            row_id       <= {RW{1'b0}};
            acc_gnt      <= 1'b0;
            refresh_flag <= 1'b0;
        end else begin
            acc_gnt <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ref_go_s) begin
                        state_r      <= REF_REQ;
                        cmd_req      <= 1'b1;
                        cmd          <= CMD_REF;
                        bank_id      <= {BW{1'b0}};
                        row_id       <= row_ptr_r;
                        refresh_flag <= 1'b1;
                    end else if (acc_valid_s) begin
                        state_r <= ACC_REQ;
                        cmd_req <= 1'b1;
                        cmd     <= acc_cmd;
                        bank_id <= acc_bank;
                        row_id  <= acc_row;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACC_REQ: begin
                    if (cmd_ack) begin
                        state_r <= ACC_REL;
                        cmd_req <= 1'b0;
                    end else begin
                        state_r <= ACC_REQ;
                    end
                end
                ACC_REL: begin
                    if (!cmd_ack) begin
                        state_r <= IDLE;
                        acc_gnt <= 1'b1;
                        cmd     <= CMD_NONE;
                    end else begin
                        state_r <= ACC_REL;
                    end
                end
                REF_REQ: begin
                    if (cmd_ack) begin
                        state_r <= REF_REL;
                        cmd_req <= 1'b0;
                    end else begin
                        state_r <= REF_REQ;
                    end
                end
                REF_REL: begin
                    if (!cmd_ack) begin
                        if (bank_id == LAST_BANK) begin
                            state_r      <= IDLE;
                            cmd          <= CMD_NONE;
                            refresh_flag <= 1'b0;
                        end else begin
                            state_r <= REF_REQ;
                            cmd_req <= 1'b1;
                            bank_id <= bank_id + BW'(1);
                            row_id  <= row_ptr_r;
                        end
                    end else begin
                        state_r <= REF_REL;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cmd_req      <= 1'b0;
                    cmd          <= CMD_NONE;
                    refresh_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_refresh_arb.sv
// Self-checking bench for dram_refresh_arb: table-driven access vectors plus
// hand-written sequences for refresh bursts, priority, overflow, row wrap and
// asynchronous reset. A refresh burst occupies 16 cycles, so the tick period
// used here is 32 to let the pending count drain between ticks.
module tb_dram_refresh_arb;

    localparam int NB = 8;
    localparam int NR = 128;
    localparam int RI = 32;
    localparam int MP = 4;
`ifdef REFRESH_POSTPONE_EN
    localparam int EXP_ACC_BEFORE_BURST = 43;
`else
    localparam int EXP_ACC_BEFORE_BURST = 11;
`endif

    typedef struct {
        logic [1:0] cmd;
        logic [2:0] bank;
        logic [6:0] row;
        bit         exp_gnt;
    } acc_vec_t;

    typedef struct {
        logic [1:0] cmd;
        logic [2:0] bank;
        logic [6:0] row;
    } cmd_rec_t;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       acc_req, acc_gnt, cmd_req, cmd_ack, refresh_flag, refresh_ovf;
    logic [1:0] acc_cmd, cmd;
    logic [2:0] acc_bank, bank_id;
    logic [6:0] acc_row, row_id;
    logic       ack_en;
    logic       prev_req = 1'b0;
    int         gnt_cnt = 0;
    cmd_rec_t   log_q[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dram_refresh_arb #(
        .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .REFRESH_INTERVAL(RI), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .rst_b(rst_b), .acc_req(acc_req), .acc_cmd(acc_cmd),
        .acc_bank(acc_bank), .acc_row(acc_row), .acc_gnt(acc_gnt),
        .cmd_req(cmd_req), .cmd(cmd), .bank_id(bank_id), .row_id(row_id),
        .cmd_ack(cmd_ack), .refresh_flag(refresh_flag), .refresh_ovf(refresh_ovf)
    );

    // DRAM-side responder: acknowledge follows request half a cycle later.
    always @(negedge clk) cmd_ack = ack_en && cmd_req;

    // Command log: one record per rising cmd_req; grant pulses counted per cycle.
    always @(negedge clk) begin
        if (rst_b && cmd_req && !prev_req) log_q.push_back('{cmd, bank_id, row_id});
        if (rst_b && acc_gnt) gnt_cnt <= gnt_cnt + 1;
        prev_req <= cmd_req;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_req"}, int'(cmd_req), 0);
        check({tag, "_cmd"}, int'(cmd), 0);
        check({tag, "_bank_id"}, int'(bank_id), 0);
        check({tag, "_row_id"}, int'(row_id), 0);
        check({tag, "_acc_gnt"}, int'(acc_gnt), 0);
        check({tag, "_refresh_flag"}, int'(refresh_flag), 0);
        check({tag, "_refresh_ovf"}, int'(refresh_ovf), 0);
        check({tag, "_pending"}, int'(dut.pending_r), 0);
    endtask

    task automatic apply_reset();
        rst_b = 1'b0;
        steps(2);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    function automatic int first_ref(input int base);
        for (int i = base; i < log_q.size(); i++)
            if (log_q[i].cmd == 2'b11) return i - base;
        return -1;
    endfunction

    acc_vec_t vecs[6];

    initial begin
        int n, base, l0, g0, idx, bad, acc_cnt;
        bit seen;
        cmd_rec_t last_acc;

        vecs[0] = '{2'b10, 3'd3, 7'd42,  1'b1};
        vecs[1] = '{2'b01, 3'd0, 7'd0,   1'b1};
        vecs[2] = '{2'b01, 3'd7, 7'd127, 1'b1};
        vecs[3] = '{2'b00, 3'd2, 7'd9,   1'b0};
        vecs[4] = '{2'b10, 3'd5, 7'd1,   1'b1};
        vecs[5] = '{2'b11, 3'd6, 7'd6,   1'b0};

        acc_req = 1'b0; acc_cmd = 2'b00; acc_bank = 3'd0; acc_row = 7'd0; ack_en = 1'b1;
        #2 rst_b = 1'b0;
        #1 check_reset_vals("por");
        apply_reset();

        // First refresh burst after one interval with no requests.
        base = log_q.size();
        steps(30);
        check("ref_idle_before_tick", int'(refresh_flag), 0);
        n = 0;
        while (!refresh_flag && n < 20) begin step(); n++; end
        check("ref_start_latency", n, 3);
        check("ref_first_cmd_req", int'(cmd_req), 1);
        check("ref_first_cmd", int'(cmd), 3);
        check("ref_first_bank", int'(bank_id), 0);
        n = 0;
        while (refresh_flag && n < 60) begin step(); n++; end
        check("ref_flag_cycles", n, 16);
        check("ref_burst_count", log_q.size() - base, 8);
        bad = 0;
        for (int i = 0; i < 8 && base + i < log_q.size(); i++)
            if (log_q[base+i].cmd != 2'b11 || int'(log_q[base+i].bank) != i || log_q[base+i].row != 7'd0)
                bad++;
        check("ref_burst_entries_bad", bad, 0);
        check("ref_pending_drained", int'(dut.pending_r), 0);

        // Single write handshake with exact cycle timing.
        acc_req = 1'b1; acc_cmd = 2'b10; acc_bank = 3'd3; acc_row = 7'd42;
        step();
        acc_req = 1'b0;
        check("wr_cmd_req_rise", int'(cmd_req), 1);
        check("wr_cmd", int'(cmd), 2);
        check("wr_bank", int'(bank_id), 3);
        check("wr_row", int'(row_id), 42);
        step();
        check("wr_cmd_req_fall", int'(cmd_req), 0);
        check("wr_cmd_held", int'(cmd), 2);
        check("wr_bank_held", int'(bank_id), 3);
        check("wr_gnt_early", int'(acc_gnt), 0);
        step();
        check("wr_gnt_pulse", int'(acc_gnt), 1);
        check("wr_cmd_none", int'(cmd), 0);
        step();
        check("wr_gnt_single", int'(acc_gnt), 0);

        // Table of access vectors, including ignored command codes.
        foreach (vecs[v]) begin
            acc_cmd = vecs[v].cmd; acc_bank = vecs[v].bank; acc_row = vecs[v].row;
            acc_req = 1'b1;
            g0 = gnt_cnt; l0 = log_q.size();
            seen = 1'b0; n = 0;
            while (!seen && n < 80) begin
                step(); n++;
                if (acc_gnt) seen = 1'b1;
            end
            if (seen) check("vec_cmd_after_gnt", int'(cmd), 0);
            acc_req = 1'b0;
            steps(2);
            check("vec_gnt_seen", int'(seen), int'(vecs[v].exp_gnt));
            check("vec_gnt_pulses", gnt_cnt - g0, int'(vecs[v].exp_gnt));
            acc_cnt = 0;
            last_acc = '{2'b00, 3'd0, 7'd0};
            for (int i = l0; i < log_q.size(); i++)
                if (log_q[i].cmd != 2'b11) begin acc_cnt++; last_acc = log_q[i]; end
            check("vec_access_count", acc_cnt, int'(vecs[v].exp_gnt));
            if (vecs[v].exp_gnt) begin
                check("vec_cmd", int'(last_acc.cmd), int'(vecs[v].cmd));
                check("vec_bank", int'(last_acc.bank), int'(vecs[v].bank));
                check("vec_row", int'(last_acc.row), int'(vecs[v].row));
            end
        end

        // Access held high across ticks: refresh waits for the handshake in flight.
        acc_req = 1'b1; acc_cmd = 2'b01; acc_bank = 3'd1; acc_row = 7'd5;
        apply_reset();
        base = log_q.size();
        n = 0;
        while (first_ref(base) < 0 && n < 400) begin step(); n++; end
        idx = first_ref(base);
        check("prio_accesses_before_burst", idx, EXP_ACC_BEFORE_BURST);
        n = 0;
        while (idx >= 0 && log_q.size() < base + idx + 9 && n < 100) begin step(); n++; end
        check("prio_log_after_burst", int'(idx >= 0 && log_q.size() >= base + idx + 9), 1);
        if (idx >= 0 && log_q.size() >= base + idx + 9) begin
            bad = 0;
            for (int i = 0; i < 8; i++)
                if (log_q[base+idx+i].cmd != 2'b11 || int'(log_q[base+idx+i].bank) != i) bad++;
            check("prio_burst_bad", bad, 0);
            check("prio_access_resumes", int'(log_q[base+idx+8].cmd), 1);
        end
        acc_req = 1'b0;

        // Stalled refresh handshake: pending saturates, fifth tick sets overflow.
        ack_en = 1'b0;
        apply_reset();
        steps(150);
        check("ovf_clear_at_full", int'(refresh_ovf), 0);
        check("ovf_pending_full", int'(dut.pending_r), 4);
        check("ovf_stall_cmd_req", int'(cmd_req), 1);
        check("ovf_stall_cmd", int'(cmd), 3);
        check("ovf_stall_flag", int'(refresh_flag), 1);
        steps(15);
        check("ovf_set", int'(refresh_ovf), 1);
        #2 rst_b = 1'b0;
        #1 check_reset_vals("mid_ref");

        // 129 bursts: row pointer walks 0..127 and wraps back to 0.
        ack_en = 1'b1;
        apply_reset();
        base = log_q.size();
        n = 0;
        while (log_q.size() - base < 129 * 8 && n < 4400) begin step(); n++; end
        check("wrap_all_bursts_seen", int'(log_q.size() - base >= 129 * 8), 1);
        if (log_q.size() - base >= 129 * 8) begin
            bad = 0;
            for (int i = 0; i < 129 * 8; i++)
                if (log_q[base+i].cmd != 2'b11 || int'(log_q[base+i].bank) != i % 8 ||
                    int'(log_q[base+i].row) != (i / 8) % 128) bad++;
            check("wrap_entries_bad", bad, 0);
            check("wrap_row_127", int'(log_q[base+127*8].row), 127);
            check("wrap_row_0", int'(log_q[base+128*8].row), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
